cmp_streak_unit: RTL and testbench
==================================

Name: cmp_streak_unit

Overview:
- Parametrised, registered successor to the team's single-purpose combinational A>B comparator.
- Compares two WIDTH-bit operands under a selectable relation (GT/GE/EQ/LT), optionally signed, with a valid qualifier and one-cycle latency.
- Tracks consecutive true results in a saturating streak counter and pulses `hit` when the streak reaches a programmable threshold, then enters a hold-off period.
- Sits between an operand source (LFSR / switch inputs / counters) and game or control FSMs that need a debounced "A beat B N times in a row" event.

Parameters:
- WIDTH, 10: operand width in bits.
- CNT_W, 4: width of streak counter and threshold.
- HOLDOFF, 3: clock cycles spent in hold-off after a hit; 0 disables hold-off.
- SIGNED, 0: 1 = two's-complement compare, 0 = unsigned.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of streak and FSM.
- in_valid  in  1  sample qualifier for a, b, mode.
- mode  in  2  relation select (cmp_mode_e).
- a  in  WIDTH  left operand.
- b  in  WIDTH  right operand.
- threshold  in  CNT_W  streak length that triggers hit; 0 means never hit.
- out_valid  out  1  registered copy of in_valid.
- cmp_out  out  1  registered result of (a mode b) for the last valid sample.
- streak  out  CNT_W  current consecutive-true count.
- hit  out  1  one-cycle pulse when streak reaches threshold.
- busy  out  1  high while in HOLDOFF.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, cmp_out=0, streak=0, hit=0, busy=0, FSM=COUNT, hold-off counter=0. Applies immediately, including mid-streak or mid-hold-off. Outputs stay at these values until the first rising edge after reset goes high.
- Latency:
  - A sample presented with in_valid=1 before edge k produces out_valid=1 and cmp_out from that sample after edge k.
  - out_valid follows in_valid with 1-cycle latency.
  - cmp_out holds its value when in_valid=0.
- Relation: GT a>b, GE a>=b, EQ a==b, LT a<b.
  - SIGNED=1: operands are treated as two's complement. SIGNED=0: unsigned.
  - mode is sampled with the operands, so a mode change takes effect on that sample.
- FSM states: COUNT, HOLDOFF.
- COUNT, valid sample:
  - True result: streak increments, saturating at 2^CNT_W-1.
  - False result: streak goes to 0.
  - in_valid=0: streak holds; gaps do not break a streak.
- Hit condition: in COUNT, a valid true sample whose incremented streak equals threshold (threshold != 0). On that edge:
  - hit=1 for one cycle.
  - streak goes to 0.
  - If HOLDOFF>0: state goes to HOLDOFF, busy=1, hold-off counter loads HOLDOFF.
  - If HOLDOFF=0: state stays COUNT.
- HOLDOFF:
  - Hold-off counter decrements every clk cycle regardless of in_valid.
  - streak is held at 0; true samples are ignored; cmp_out and out_valid still update normally.
  - When the counter reaches 0, state returns to COUNT and busy=0 on the same edge. busy is therefore high for exactly HOLDOFF cycles.
- Saturation: a streak at max stays at max. If threshold exceeds the max it is simply never reached; no wrap-around.
- clear=1:
  - Next edge: streak=0, state=COUNT, busy=0, hit=0.
  - clear has priority over a simultaneous hit.
  - cmp_out and out_valid still update from a simultaneous valid sample.
- threshold is sampled every cycle; lowering it below the current streak does not produce a hit until the streak resets and climbs again.

Decomposition:
- Package cmp_pkg:
  - typedef enum logic [1:0] cmp_mode_e {CMP_GT=0, CMP_GE=1, CMP_EQ=2, CMP_LT=3}.
  - typedef enum logic cmp_state_e {ST_COUNT, ST_HOLDOFF}.
- Sub-module cmp_core (parameters WIDTH, SIGNED): purely combinational relation evaluator (a, b, mode -> result), instantiated once. All sequential logic lives in cmp_streak_unit.

Test Plan (WIDTH=10, CNT_W=4, HOLDOFF=3, SIGNED=0 unless noted):
1. Relations: a=0x072, b=0x072 under GT/GE/EQ/LT -> cmp_out 0/1/1/0. a=0x244, b=0x1F8 GT -> 1. a=0x0F9, b=0x0D7 LT -> 0. Each result appears one edge after in_valid.
2. Hit and hold-off: threshold=3, three consecutive valid GT-true samples -> streak 1,2,0; hit pulses on the third edge. busy=1 for exactly 3 cycles; true samples during busy leave streak=0; streak counts from 1 afterward.
3. Gaps and breaks: threshold=3, samples true, true, in_valid=0 x2, false, true -> streak 1,2,2,2,0,1. hit never asserts; out_valid pattern 1,1,0,0,1,1.
4. Saturation: threshold=0, 20 consecutive true samples -> streak climbs to 15 and holds at 15. hit and busy stay 0.
5. Signed: a=0x3FF, b=0x001, mode LT -> cmp_out=1 with SIGNED=1 and 0 with SIGNED=0.
6. Reset/clear: drive reset low at streak=2 or mid-HOLDOFF -> all outputs 0 immediately, before any edge. With streak=2, threshold=3, clear=1 together with a true sample -> streak=0, hit=0, cmp_out=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the registered compare/streak unit.
// Relation select and streak FSM state encodings.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_GT = 2'd0,
    CMP_GE = 2'd1,
    CMP_EQ = 2'd2,
    CMP_LT = 2'd3
  } cmp_mode_e;

  typedef enum logic {
    ST_COUNT   = 1'b0,
    ST_HOLDOFF = 1'b1
  } cmp_state_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational relation evaluator: a <mode> b.
// Signedness is fixed at elaboration time.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  cmp_mode_e        mode,
  output logic             result
);

  logic gt;
  logic eq;

  always_comb begin
    eq = (a == b);
    if (SIGNED) gt = ($signed(a) > $signed(b));
    else        gt = (a > b);
  end

  always_comb begin
    result = 1'b0;
    unique case (mode)
      CMP_GT: result = gt;
      CMP_GE: result = gt | eq;
      CMP_EQ: result = eq;
      CMP_LT: result = ~(gt | eq);
    endcase
  end

endmodule

// File: rtl/cmp_streak_unit.sv
// Registered comparator with saturating true-streak counter,
// threshold hit pulse and post-hit hold-off window.
module cmp_streak_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int CNT_W   = 4,
  parameter int HOLDOFF = 3,
  parameter bit SIGNED  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNT_W-1:0] threshold,
  output logic             out_valid,
  output logic             cmp_out,
  output logic [CNT_W-1:0] streak,
  output logic             hit,
  output logic             busy
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF);
  localparam logic [CNT_W-1:0] MAXC = '1;

  cmp_state_e    state;
  logic [HW-1:0] hcnt;
  logic          res;
  logic [CNT_W-1:0] inc;
  logic          hit_c;

  cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a      (a),
    .b      (b),
    .mode   (cmp_mode_e'(mode)),
    .result (res)
  );

  always_comb begin
    inc   = (streak == MAXC) ? MAXC : streak + CNT_W'(1);
    hit_c = res && (threshold != '0) && (inc == threshold);
  end

  assign busy = (state == ST_HOLDOFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      cmp_out   <= 1'b0;
      streak    <= '0;
      hit       <= 1'b0;
      state     <= ST_COUNT;
      hcnt      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) cmp_out <= res;
      hit <= 1'b0;
      if (clear) begin
        streak <= '0;
        state  <= ST_COUNT;
        hcnt   <= '0;
      end else if (state == ST_HOLDOFF) begin
        streak <= '0;
        // leave hold-off on the edge the counter hits zero
        if (hcnt <= HW'(1)) begin
          state <= ST_COUNT;
          hcnt  <= '0;
        end else begin
          hcnt <= hcnt - HW'(1);
        end
      end else if (in_valid) begin
        if (!res) begin
          streak <= '0;
        end else if (hit_c) begin
          hit    <= 1'b1;
          streak <= '0;
          if (HOLDOFF > 0) begin
            state <= ST_HOLDOFF;
            hcnt  <= HOLD_LD;
          end
        end else begin
          streak <= inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_streak_unit.sv
// Directed scoreboard bench for cmp_streak_unit (unsigned + signed).
// Expected outputs are queued at drive time and checked after the edge.
module tb_cmp_streak_unit;

  localparam int W = 10;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         in_valid;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [C-1:0] threshold;

  logic         ov0, co0, h0, bz0;
  logic [C-1:0] st0;
  logic         ov1, co1, h1, bz1;
  logic [C-1:0] st1;

  always #5 clk = ~clk;

  cmp_streak_unit #(
    .WIDTH(W), .CNT_W(C), .HOLDOFF(3), .SIGNED(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .mode(mode), .a(a), .b(b), .threshold(threshold),
    .out_valid(ov0), .cmp_out(co0), .streak(st0), .hit(h0), .busy(bz0)
  );

  cmp_streak_unit #(
    .WIDTH(W), .CNT_W(C), .HOLDOFF(3), .SIGNED(1'b1)
  ) u_sdut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .mode(mode), .a(a), .b(b), .threshold(threshold),
    .out_valid(ov1), .cmp_out(co1), .streak(st1), .hit(h1), .busy(bz1)
  );

  typedef struct {
    string        tag;
    logic         ov;
    logic         co;
    logic [C-1:0] st;
    logic         h;
    logic         bz;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic last_co = 1'b0;

  localparam logic [1:0] GT = 2'd0;
  localparam logic [1:0] GE = 2'd1;
  localparam logic [1:0] EQ = 2'd2;
  localparam logic [1:0] LT = 2'd3;

  function automatic logic ref_cmp(input logic [1:0] m,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input bit sgn);
    int sx, sy;
    sx = sgn ? int'($signed(x)) : int'(x);
    sy = sgn ? int'($signed(y)) : int'(y);
    case (m)
      GT:      return sx > sy;
      GE:      return sx >= sy;
      EQ:      return sx == sy;
      default: return sx < sy;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] m,
                      input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic clr, input logic [C-1:0] est,
                      input logic eh, input logic ebz);
    exp_t e;
    in_valid = v;
    mode     = m;
    a        = x;
    b        = y;
    clear    = clr;
    if (v) last_co = ref_cmp(m, x, y, 1'b0);
    e.tag = tag; e.ov = v; e.co = last_co;
    e.st = est; e.h = eh; e.bz = ebz;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".ov"}, 32'(ov0), 32'(e.ov));
    chk({e.tag, ".cmp"}, 32'(co0), 32'(e.co));
    chk({e.tag, ".streak"}, 32'(st0), 32'(e.st));
    chk({e.tag, ".hit"}, 32'(h0), 32'(e.h));
    chk({e.tag, ".busy"}, 32'(bz0), 32'(e.bz));
    clear = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, ".ov"}, 32'(ov0), 32'd0);
    chk({tag, ".cmp"}, 32'(co0), 32'd0);
    chk({tag, ".streak"}, 32'(st0), 32'd0);
    chk({tag, ".hit"}, 32'(h0), 32'd0);
    chk({tag, ".busy"}, 32'(bz0), 32'd0);
    in_valid = 1'b0;
    clear    = 1'b0;
    reset    = 1'b1;
    last_co  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    mode = GT; a = '0; b = '0; threshold = '0;
    @(posedge clk);
    #1;
    reset_pulse("reset0");

    // relations
    threshold = 4'd0;
    step("rel_gt", 1, GT, 10'h072, 10'h072, 0, 4'd0, 0, 0);
    step("rel_ge", 1, GE, 10'h072, 10'h072, 0, 4'd1, 0, 0);
    step("rel_eq", 1, EQ, 10'h072, 10'h072, 0, 4'd2, 0, 0);
    step("rel_lt", 1, LT, 10'h072, 10'h072, 0, 4'd0, 0, 0);
    step("rel_gt2", 1, GT, 10'h244, 10'h1F8, 0, 4'd1, 0, 0);
    step("rel_lt2", 1, LT, 10'h0F9, 10'h0D7, 0, 4'd0, 0, 0);

    // hit and hold-off
    threshold = 4'd3;
    step("hit_1", 1, GT, 10'd5, 10'd1, 0, 4'd1, 0, 0);
    step("hit_2", 1, GT, 10'd5, 10'd1, 0, 4'd2, 0, 0);
    step("hit_3", 1, GT, 10'd5, 10'd1, 0, 4'd0, 1, 1);
    step("hold_1", 1, GT, 10'd5, 10'd1, 0, 4'd0, 0, 1);
    step("hold_2", 1, GT, 10'd5, 10'd1, 0, 4'd0, 0, 1);
    step("hold_end", 1, GT, 10'd5, 10'd1, 0, 4'd0, 0, 0);
    step("post_1", 1, GT, 10'd5, 10'd1, 0, 4'd1, 0, 0);
    step("post_brk", 1, GT, 10'd1, 10'd5, 0, 4'd0, 0, 0);

    // gaps keep the streak, a false sample breaks it
    step("gap_t1", 1, GT, 10'd9, 10'd2, 0, 4'd1, 0, 0);
    step("gap_t2", 1, GT, 10'd9, 10'd2, 0, 4'd2, 0, 0);
    step("gap_n1", 0, GT, 10'd0, 10'd9, 0, 4'd2, 0, 0);
    step("gap_n2", 0, GT, 10'd0, 10'd9, 0, 4'd2, 0, 0);
    step("gap_f", 1, GT, 10'd2, 10'd9, 0, 4'd0, 0, 0);
    step("gap_t3", 1, GT, 10'd9, 10'd2, 0, 4'd1, 0, 0);
    step("gap_brk", 1, EQ, 10'd9, 10'd2, 0, 4'd0, 0, 0);

    // saturation with threshold disabled
    threshold = 4'd0;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_%0d", i), 1, GE, 10'h3FF, 10'h3FF, 0,
           (i < 15) ? C'(i + 1) : 4'd15, 0, 0);
    end
    step("sat_brk", 1, LT, 10'h3FF, 10'h3FF, 0, 4'd0, 0, 0);

    // signed vs unsigned
    step("uns_lt", 1, LT, 10'h3FF, 10'h001, 0, 4'd0, 0, 0);
    chk("sgn_lt.cmp", 32'(co1), 32'(ref_cmp(LT, 10'h3FF, 10'h001, 1'b1)));
    chk("sgn_lt.ov", 32'(ov1), 32'd1);

    // lowering threshold under the streak gives no hit
    threshold = 4'd3;
    step("thr_1", 1, GT, 10'd7, 10'd3, 0, 4'd1, 0, 0);
    step("thr_2", 1, GT, 10'd7, 10'd3, 0, 4'd2, 0, 0);
    threshold = 4'd1;
    step("thr_low", 1, GT, 10'd7, 10'd3, 0, 4'd3, 0, 0);
    step("thr_brk", 1, GT, 10'd3, 10'd7, 0, 4'd0, 0, 0);
    threshold = 4'd3;

    // async reset mid-streak
    step("rs_1", 1, GT, 10'd7, 10'd3, 0, 4'd1, 0, 0);
    step("rs_2", 1, GT, 10'd7, 10'd3, 0, 4'd2, 0, 0);
    reset_pulse("rst_streak");
    step("rs_after", 1, GT, 10'd7, 10'd3, 0, 4'd1, 0, 0);
    step("rs_brk", 1, LT, 10'd7, 10'd3, 0, 4'd0, 0, 0);

    // async reset mid-hold-off
    step("rh_1", 1, GT, 10'd7, 10'd3, 0, 4'd1, 0, 0);
    step("rh_2", 1, GT, 10'd7, 10'd3, 0, 4'd2, 0, 0);
    step("rh_hit", 1, GT, 10'd7, 10'd3, 0, 4'd0, 1, 1);
    step("rh_hold", 1, GT, 10'd7, 10'd3, 0, 4'd0, 0, 1);
    reset_pulse("rst_hold");
    step("rh_after", 1, GT, 10'd7, 10'd3, 0, 4'd1, 0, 0);

    // clear beats a simultaneous hit
    step("clr_2", 1, GT, 10'd7, 10'd3, 0, 4'd2, 0, 0);
    step("clr_hit", 1, GT, 10'd7, 10'd3, 1, 4'd0, 0, 0);
    step("clr_next", 1, GT, 10'd7, 10'd3, 0, 4'd1, 0, 0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
